// File: rtl/ghost_move_checker.sv
// Neighbour-tile passability checker for one ghost: walks Up/Right/Down/Left
// through the maze ROM and publishes all four canMove flags together with done.
module ghost_move_checker #(
  parameter int MAP_W      = 28,
  parameter int MAP_H      = 36,
  parameter int TUNNEL_ROW = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [5:0] ghostX,
  input  logic [5:0] ghostY,
  input  logic       allowDoor,
  output logic [9:0] mem_addr,
  input  logic [1:0] mem_data,
  output logic       busy,
  output logic       done,
  output logic       canMoveUp,
  output logic       canMoveRight,
  output logic       canMoveDown,
  output logic       canMoveLeft
);

  localparam logic [5:0] W6   = 6'(MAP_W);
  localparam logic [5:0] H6   = 6'(MAP_H);
  localparam logic [5:0] WM1  = 6'(MAP_W - 1);
  localparam logic [5:0] HM1  = 6'(MAP_H - 1);
  localparam logic [5:0] TR6  = 6'(TUNNEL_ROW);
  localparam logic [9:0] W10  = 10'(MAP_W);

  typedef enum logic [2:0] {IDLE, A_UP, A_RIGHT, A_DOWN, A_LEFT, W_LAST} state_t;

  state_t     state, state_nx;
  logic [5:0] x_q, y_q;
  logic       door_q;
  logic       sh_up, sh_right, sh_down;

  logic       in_range, tunnel;
  logic       up_ok, down_ok, left_ok, right_ok;
  logic [5:0] left_x, right_x;
  logic       pass;

  function automatic logic [9:0] tile_addr(input logic [5:0] ty, input logic [5:0] tx);
    return 10'(ty) * W10 + 10'(tx);
  endfunction

  assign in_range = (x_q < W6) && (y_q < H6);
  assign tunnel   = (y_q == TR6);
  assign up_ok    = in_range && (y_q != '0);
  assign down_ok  = in_range && (y_q != HM1);
  assign left_ok  = in_range && ((x_q != '0) || tunnel);
  assign right_ok = in_range && ((x_q != WM1) || tunnel);
  assign left_x   = (x_q == '0)  ? WM1 : x_q - 6'd1;
  assign right_x  = (x_q == WM1) ? '0  : x_q + 6'd1;

  // Door tiles are passable only when the ghost was granted door access.
  assign pass = (mem_data == 2'b01) ? 1'b0 :
                (mem_data == 2'b10) ? door_q : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = A_UP;
      A_UP:    state_nx = A_RIGHT;
      A_RIGHT: state_nx = A_DOWN;
      A_DOWN:  state_nx = A_LEFT;
      A_LEFT:  state_nx = W_LAST;
      W_LAST:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_addr = '0;
    busy     = (state != IDLE);
    case (state)
      A_UP:    if (up_ok)    mem_addr = tile_addr(y_q - 6'd1, x_q);
      A_RIGHT: if (right_ok) mem_addr = tile_addr(y_q, right_x);
      A_DOWN:  if (down_ok)  mem_addr = tile_addr(y_q + 6'd1, x_q);
      A_LEFT:  if (left_ok)  mem_addr = tile_addr(y_q, left_x);
      default: mem_addr = '0;
    endcase
  end

  // ROM data lags the address by one state, so each capture uses the
  // previous direction's validity; Left goes straight to the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      door_q       <= 1'b0;
      sh_up        <= 1'b0;
      sh_right     <= 1'b0;
      sh_down      <= 1'b0;
      done         <= 1'b0;
      canMoveUp    <= 1'b0;
      canMoveRight <= 1'b0;
      canMoveDown  <= 1'b0;
      canMoveLeft  <= 1'b0;
    end else begin
      done <= (state == W_LAST);
      case (state)
        IDLE: if (req) begin
          x_q    <= ghostX;
          y_q    <= ghostY;
          door_q <= allowDoor;
        end
        A_RIGHT: sh_up    <= up_ok    && pass;
        A_DOWN:  sh_right <= right_ok && pass;
        A_LEFT:  sh_down  <= down_ok  && pass;
        W_LAST: begin
          canMoveUp    <= sh_up;
          canMoveRight <= sh_right;
          canMoveDown  <= sh_down;
          canMoveLeft  <= left_ok && pass;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ghost_move_checker.sv
// Randomized self-checking bench for ghost_move_checker against a tile-level model.
module tb_ghost_move_checker;

  localparam int MAP_W      = 28;
  localparam int MAP_H      = 36;
  localparam int TUNNEL_ROW = 17;

  logic       clk = 1'b0;
  logic       reset, req, allowDoor;
  logic [5:0] ghostX, ghostY;
  logic [9:0] mem_addr;
  logic [1:0] mem_data;
  logic       busy, done, canMoveUp, canMoveRight, canMoveDown, canMoveLeft;

  logic [1:0] rom [0:1023];
  int checks = 0;
  int failures = 0;

  ghost_move_checker #(.MAP_W(MAP_W), .MAP_H(MAP_H), .TUNNEL_ROW(TUNNEL_ROW)) dut (
    .clk(clk), .reset(reset), .req(req), .ghostX(ghostX), .ghostY(ghostY),
    .allowDoor(allowDoor), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done), .canMoveUp(canMoveUp), .canMoveRight(canMoveRight),
    .canMoveDown(canMoveDown), .canMoveLeft(canMoveLeft)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= rom[mem_addr];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Neighbour d (0=up,1=right,2=down,3=left) of tile (x,y): reachable flag and ROM address.
  function automatic void neighbour(input int x, input int y, input int d,
                                    output bit ok, output int addr);
    int nx = x, ny = y;
    case (d)
      0: ny = y - 1;
      1: begin nx = x + 1; if (nx == MAP_W && y == TUNNEL_ROW) nx = 0; end
      2: ny = y + 1;
      default: begin nx = x - 1; if (nx < 0 && y == TUNNEL_ROW) nx = MAP_W - 1; end
    endcase
    ok = (x < MAP_W) && (y < MAP_H) && nx >= 0 && nx < MAP_W && ny >= 0 && ny < MAP_H;
    addr = ok ? ny * MAP_W + nx : 0;
  endfunction

  function automatic bit enterable(input logic [1:0] code, input bit door);
    return (code == 2'b00) || (code == 2'b11) || (code == 2'b10 && door);
  endfunction

  // Runs one query starting in cycle 0; returns at cycle 6 (+1 time unit).
  task automatic query(input int x, input int y, input bit door, input bit inject, input bit b2b);
    int  ea[4];
    bit  ok;
    logic [3:0] ef;
    for (int d = 0; d < 4; d++) begin
      neighbour(x, y, d, ok, ea[d]);
      ef[3-d] = ok && enterable(rom[ea[d]], door);
    end
    if (!b2b) begin @(posedge clk); #1; end
    req = 1'b1; ghostX = 6'(x); ghostY = 6'(y); allowDoor = door;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c <= 4) check($sformatf("addr_c%0d", c), int'(mem_addr), ea[c-1]);
      check($sformatf("busy_c%0d", c), int'(busy), int'(c <= 5));
      check($sformatf("done_c%0d", c), int'(done), int'(c == 6));
      if (c == 6)
        check("flags_URDL", int'({canMoveUp, canMoveRight, canMoveDown, canMoveLeft}), int'(ef));
      req = inject && (c == 2 || c == 4);
      if (req) begin
        ghostX = 6'($urandom_range(0, 63));
        ghostY = 6'($urandom_range(0, 63));
        allowDoor = 1'($urandom);
      end
    end
  endtask

  task automatic fill_rom(input bit rnd);
    for (int i = 0; i < 1024; i++) rom[i] = rnd ? 2'($urandom) : 2'b00;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; ghostX = '0; ghostY = '0; allowDoor = 1'b0;
    fill_rom(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_flags", int'({canMoveUp, canMoveRight, canMoveDown, canMoveLeft}), 0);
    reset = 1'b0;

    query(6, 5, 1'b0, 1'b0, 1'b0);                 // open cross
    rom[377] = 2'b10; rom[406] = 2'b01; rom[433] = 2'b11; rom[404] = 2'b00;
    query(13, 14, 1'b0, 1'b0, 1'b0);
    query(13, 14, 1'b1, 1'b0, 1'b0);
    rom[503] = 2'b01; query(0, 17, 1'b1, 1'b0, 1'b0);
    rom[503] = 2'b00; query(0, 17, 1'b1, 1'b0, 1'b0);
    rom[476] = 2'b01; query(27, 17, 1'b0, 1'b0, 1'b0);
    query(0, 5, 1'b0, 1'b0, 1'b0);
    query(27, 5, 1'b0, 1'b0, 1'b0);
    query(4, 0, 1'b0, 1'b0, 1'b0);
    query(4, 35, 1'b0, 1'b0, 1'b0);
    query(40, 5, 1'b0, 1'b0, 1'b0);
    query(6, 5, 1'b0, 1'b1, 1'b0);                 // ignored reqs while busy
    query(13, 14, 1'b1, 1'b0, 1'b1);               // back-to-back

    // Reset mid-query with flags previously all 1.
    fill_rom(1'b0);
    query(6, 5, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req = 1'b1; ghostX = 6'd13; ghostY = 6'd14; allowDoor = 1'b0;
    @(posedge clk); #1; req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b1;              // cycle 3
    @(posedge clk); #1; reset = 1'b0;              // cycle 4
    check("abort_flags", int'({canMoveUp, canMoveRight, canMoveDown, canMoveLeft}), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;                            // cycle 6
    check("abort_no_done", int'(done), 0);
    query(6, 5, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int x, y;
      fill_rom(1'b1);
      case ($urandom_range(0, 3))
        0:       x = 0;
        1:       x = MAP_W - 1;
        default: x = $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 4))
        0:       y = 0;
        1:       y = MAP_H - 1;
        2:       y = TUNNEL_ROW;
        default: y = $urandom_range(0, 39);
      endcase
      query(x, y, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
